nf_10g_if_cpu_regs: RTL and testbench

- AXI4-Lite slave register file for the NetFPGA SUME shared-logic 10GE interface.
- Exposes identification, control, packet counters and MAC/PCS-PMA status to the host CPU.
- Sits beside the 10GE MAC/PCS block; the interface wrapper computes all ip2cpu values and this block only stores, decodes and returns them.

---
 rtl/nf_10g_if_regs_pkg.sv | 42 ++++
 rtl/nf_axil_slave_if.sv | 141 ++++++++++++++
 rtl/nf_10g_if_cpu_regs.sv | 226 ++++++++++++++++++++++
 tb/tb_nf_10g_if_cpu_regs.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf_10g_if_regs_pkg.sv
// Shared definitions for the NetFPGA SUME 10GE interface CPU register file.
// Holds the register byte offsets (relative to C_BASE_ADDRESS), the reset
// defaults of the identification words, the value returned for unmapped
// reads, and the state encodings of the AXI4-Lite handshake FSMs.
package nf_10g_if_regs_pkg;

  // Register byte offsets
  localparam logic [31:0] OFF_ID              = 32'h0000_0000;
  localparam logic [31:0] OFF_VERSION         = 32'h0000_0004;
  localparam logic [31:0] OFF_RESET           = 32'h0000_0008;
  localparam logic [31:0] OFF_FLIP            = 32'h0000_000C;
  localparam logic [31:0] OFF_DEBUG           = 32'h0000_0010;
  localparam logic [31:0] OFF_INTERFACEID     = 32'h0000_0014;
  localparam logic [31:0] OFF_PKTIN           = 32'h0000_0018;
  localparam logic [31:0] OFF_PKTOUT          = 32'h0000_001C;
  localparam logic [31:0] OFF_MACSTATUSVECTOR = 32'h0000_0020;
  localparam logic [31:0] OFF_PCSPMASTATUS    = 32'h0000_0024;
  localparam logic [31:0] OFF_PCSPMA_VEC0     = 32'h0000_0028;
  localparam logic [31:0] OFF_PCSPMA_VEC13    = 32'h0000_005C;

  localparam int unsigned PCSPMA_VEC_N = 14;

  // Defaults
  localparam logic [31:0] ID_DEFAULT      = 32'h0000_DA06;
  localparam logic [31:0] VERSION_DEFAULT = 32'h0000_0001;
  localparam logic [31:0] REG_DEFAULT     = 32'h0000_0000;
  localparam logic [31:0] UNMAPPED_RDATA  = 32'hDEAD_BEEF;

  // Handshake FSM states
  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ACK,
    WR_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ACK,
    RD_RESP
  } rd_state_e;

endpackage

// File: rtl/nf_axil_slave_if.sv
// AXI4-Lite slave handshake engine for the 10GE interface register file.
// Runs one write FSM and one independent read FSM so a read and a write can
// be served in the same cycle. Produces one-cycle wr_en / rd_en strobes
// (coincident with the AWREADY/WREADY and ARREADY pulses) together with the
// latched address, write data and byte strobes for the register decode.
// Ports:
//   clk, resetn               clock, synchronous active-low reset
//   S_AXI_AW*/W*/B*           AXI4-Lite write address/data/response
//   S_AXI_AR*/R*              AXI4-Lite read address/data
//   wr_en/wr_addr/wr_data/wr_strb  write strobe and latched write beat
//   rd_en/rd_addr             read strobe and latched read address
//   rd_data                   decoded read value, captured while rd_en
module nf_axil_slave_if
  import nf_10g_if_regs_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic                          wr_en,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]                   wr_data,
  output logic [3:0]                    wr_strb,
  output logic                          rd_en,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] rd_addr,
  input  logic [31:0]                   rd_data
);

  wr_state_e wr_state;
  rd_state_e rd_state;

  // The handshake cycle is the one where the READY pulse is high
  assign wr_en = S_AXI_AWREADY;
  assign rd_en = S_AXI_ARREADY;

  // Write FSM: accept -> READY pulse (register update) -> BVALID until BREADY
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state      <= WR_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            wr_state      <= WR_ACK;
          end
        end
        WR_ACK: begin
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY  <= 1'b0;
          S_AXI_BVALID  <= 1'b1;
          wr_state      <= WR_RESP;
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            wr_state     <= WR_IDLE;
          end
        end
        default: begin
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY  <= 1'b0;
          S_AXI_BVALID  <= 1'b0;
          wr_state      <= WR_IDLE;
        end
      endcase
    end
  end

  // Write beat capture (data path, no reset)
  always_ff @(posedge clk) begin
    if (wr_state == WR_IDLE) begin
      wr_addr <= S_AXI_AWADDR;
      wr_data <= S_AXI_WDATA;
      wr_strb <= S_AXI_WSTRB;
    end
  end

  // Read FSM: accept -> ARREADY pulse (RDATA captured) -> RVALID until RREADY
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state      <= RD_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (S_AXI_ARVALID) begin
            S_AXI_ARREADY <= 1'b1;
            rd_state      <= RD_ACK;
          end
        end
        RD_ACK: begin
          S_AXI_ARREADY <= 1'b0;
          S_AXI_RVALID  <= 1'b1;
          S_AXI_RDATA   <= rd_data;
          rd_state      <= RD_RESP;
        end
        RD_RESP: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            rd_state     <= RD_IDLE;
          end
        end
        default: begin
          S_AXI_ARREADY <= 1'b0;
          S_AXI_RVALID  <= 1'b0;
          rd_state      <= RD_IDLE;
        end
      endcase
    end
  end

  // Read address capture (data path, no reset)
  always_ff @(posedge clk) begin
    if (rd_state == RD_IDLE) begin
      rd_addr <= S_AXI_ARADDR;
    end
  end

endmodule

// File: rtl/nf_10g_if_cpu_regs.sv
// AXI4-Lite CPU register file for the NetFPGA SUME 10GE interface.
// Stores the CPU-written control words (self-clearing RESET, FLIP, DEBUG),
// decodes reads of the identification, counter and MAC/PCS-PMA status words
// computed by the interface wrapper, and pulses clear-on-read strobes for the
// packet counters. Unmapped reads return 32'hDEADBEEF; unmapped writes are
// dropped; BRESP/RRESP are always OKAY.
// Build option: define NF_10G_PCSPMA_VECTOR_EN to make the 14
// PCSPMASTATUSVECTOR words (0x28..0x5C) readable; otherwise they read 0.
// Ports:
//   clk, resetn               clock, synchronous active-low reset
//   S_AXI_*                   AXI4-Lite slave
//   *_reg inputs              read-only values from the wrapper
//   reset_reg                 self-clearing control word
//   cpu2ip_flip_reg/debug_reg CPU-written values
//   pktin/pktout_reg_clear    one-cycle clear-on-read pulses
//   resetn_sync               resetn registered once
module nf_10g_if_cpu_regs
  import nf_10g_if_regs_pkg::*;
#(
  parameter logic [31:0] C_BASE_ADDRESS     = 32'h0000_0000,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  input  logic [31:0]                   id_reg,
  input  logic [31:0]                   version_reg,
  input  logic [31:0]                   interfaceid_reg,
  input  logic [31:0]                   pktin_reg,
  input  logic [31:0]                   pktout_reg,
  input  logic [31:0]                   pcspmastatus_reg,
  input  logic [31:0]                   ip2cpu_flip_reg,
  input  logic [31:0]                   ip2cpu_debug_reg,
  input  logic [31:0]                   macstatusvector_reg,
  input  logic [31:0]                   pcspmastatusvector0_reg,
  input  logic [31:0]                   pcspmastatusvector1_reg,
  input  logic [31:0]                   pcspmastatusvector2_reg,
  input  logic [31:0]                   pcspmastatusvector3_reg,
  input  logic [31:0]                   pcspmastatusvector4_reg,
  input  logic [31:0]                   pcspmastatusvector5_reg,
  input  logic [31:0]                   pcspmastatusvector6_reg,
  input  logic [31:0]                   pcspmastatusvector7_reg,
  input  logic [31:0]                   pcspmastatusvector8_reg,
  input  logic [31:0]                   pcspmastatusvector9_reg,
  input  logic [31:0]                   pcspmastatusvector10_reg,
  input  logic [31:0]                   pcspmastatusvector11_reg,
  input  logic [31:0]                   pcspmastatusvector12_reg,
  input  logic [31:0]                   pcspmastatusvector13_reg,
  output logic [31:0]                   reset_reg,
  output logic [31:0]                   cpu2ip_flip_reg,
  output logic [31:0]                   cpu2ip_debug_reg,
  output logic                          pktin_reg_clear,
  output logic                          pktout_reg_clear,
  output logic                          resetn_sync
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;

  logic [31:0]   wr_off;
  logic [31:0]   rd_off;
  logic [31:0]   wr_key;
  logic [31:0]   rd_key;
  logic [31:0]   vec_idx;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] nxt,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = nxt[8*b +: 8];
    end
    return res;
  endfunction

  nf_axil_slave_if #(
    .C_S_AXI_ADDR_WIDTH(AW)
  ) u_axil (
    .clk          (clk),
    .resetn       (resetn),
    .S_AXI_AWADDR (S_AXI_AWADDR),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA  (S_AXI_WDATA),
    .S_AXI_WSTRB  (S_AXI_WSTRB),
    .S_AXI_WVALID (S_AXI_WVALID),
    .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BVALID (S_AXI_BVALID),
    .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARADDR (S_AXI_ARADDR),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA  (S_AXI_RDATA),
    .S_AXI_RVALID (S_AXI_RVALID),
    .S_AXI_RREADY (S_AXI_RREADY),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_strb      (wr_strb),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  // Decode only the word bits of the base-relative address; byte lanes ignored
  assign wr_off = 32'(wr_addr) - C_BASE_ADDRESS;
  assign rd_off = 32'(rd_addr) - C_BASE_ADDRESS;
  assign wr_key = 32'({wr_off[AW-1:2], 2'b00});
  assign rd_key = 32'({rd_off[AW-1:2], 2'b00});
  assign vec_idx = (rd_key - OFF_PCSPMA_VEC0) >> 2;

`ifdef NF_10G_PCSPMA_VECTOR_EN
  logic [31:0] pcspma_vec [PCSPMA_VEC_N];
  assign pcspma_vec[0]  = pcspmastatusvector0_reg;
  assign pcspma_vec[1]  = pcspmastatusvector1_reg;
  assign pcspma_vec[2]  = pcspmastatusvector2_reg;
  assign pcspma_vec[3]  = pcspmastatusvector3_reg;
  assign pcspma_vec[4]  = pcspmastatusvector4_reg;
  assign pcspma_vec[5]  = pcspmastatusvector5_reg;
  assign pcspma_vec[6]  = pcspmastatusvector6_reg;
  assign pcspma_vec[7]  = pcspmastatusvector7_reg;
  assign pcspma_vec[8]  = pcspmastatusvector8_reg;
  assign pcspma_vec[9]  = pcspmastatusvector9_reg;
  assign pcspma_vec[10] = pcspmastatusvector10_reg;
  assign pcspma_vec[11] = pcspmastatusvector11_reg;
  assign pcspma_vec[12] = pcspmastatusvector12_reg;
  assign pcspma_vec[13] = pcspmastatusvector13_reg;
  logic unused_dec;
  assign unused_dec = ^{wr_off, rd_off, vec_idx[31:4]};
`else
  logic unused_dec;
  assign unused_dec = ^{wr_off, rd_off, vec_idx,
                        pcspmastatusvector0_reg,  pcspmastatusvector1_reg,
                        pcspmastatusvector2_reg,  pcspmastatusvector3_reg,
                        pcspmastatusvector4_reg,  pcspmastatusvector5_reg,
                        pcspmastatusvector6_reg,  pcspmastatusvector7_reg,
                        pcspmastatusvector8_reg,  pcspmastatusvector9_reg,
                        pcspmastatusvector10_reg, pcspmastatusvector11_reg,
                        pcspmastatusvector12_reg, pcspmastatusvector13_reg};
`endif

  // Read decode; sampled into RDATA at the end of the ARREADY cycle, so a
  // write committing on the same edge is not yet visible.
  always_comb begin
    rd_data = UNMAPPED_RDATA;
    case (rd_key)
      OFF_ID:              rd_data = id_reg;
      OFF_VERSION:         rd_data = version_reg;
      OFF_RESET:           rd_data = reset_reg;
      OFF_FLIP:            rd_data = ip2cpu_flip_reg;
      OFF_DEBUG:           rd_data = ip2cpu_debug_reg;
      OFF_INTERFACEID:     rd_data = interfaceid_reg;
      OFF_PKTIN:           rd_data = pktin_reg;
      OFF_PKTOUT:          rd_data = pktout_reg;
      OFF_MACSTATUSVECTOR: rd_data = macstatusvector_reg;
      OFF_PCSPMASTATUS:    rd_data = pcspmastatus_reg;
      default: begin
        if (rd_key >= OFF_PCSPMA_VEC0 && rd_key <= OFF_PCSPMA_VEC13) begin
`ifdef NF_10G_PCSPMA_VECTOR_EN
          rd_data = pcspma_vec[vec_idx[3:0]];
`else
          rd_data = 32'h0;
`endif
        end
      end
    endcase
  end

  // Clear strobes coincide with the read-address handshake; the wrapper
  // clears its counter on the same edge that captures the pre-clear value.
  assign pktin_reg_clear  = rd_en && (rd_key == OFF_PKTIN);
  assign pktout_reg_clear = rd_en && (rd_key == OFF_PKTOUT);

  // Register update on the write handshake edge
  always_ff @(posedge clk) begin
    if (!resetn) begin
      reset_reg        <= REG_DEFAULT;
      cpu2ip_flip_reg  <= REG_DEFAULT;
      cpu2ip_debug_reg <= REG_DEFAULT;
    end else begin
      // reset_reg holds a written value for a single cycle only
      reset_reg <= '0;
      if (wr_en) begin
        case (wr_key)
          OFF_RESET: reset_reg        <= byte_merge(reset_reg, wr_data, wr_strb);
          OFF_FLIP:  cpu2ip_flip_reg  <= byte_merge(cpu2ip_flip_reg, wr_data, wr_strb);
          OFF_DEBUG: cpu2ip_debug_reg <= byte_merge(cpu2ip_debug_reg, wr_data, wr_strb);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    resetn_sync <= resetn;
  end

endmodule

// File: tb/tb_nf_10g_if_cpu_regs.sv
module tb_nf_10g_if_cpu_regs;

  logic        clk;
  logic        resetn;
  logic [11:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [11:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [31:0] id_reg, version_reg, interfaceid_reg, pktin_reg, pktout_reg;
  logic [31:0] pcspmastatus_reg, ip2cpu_flip_reg, ip2cpu_debug_reg, macstatusvector_reg;
  logic [31:0] pvec [14];
  logic [31:0] reset_reg, cpu2ip_flip_reg, cpu2ip_debug_reg;
  logic        pktin_reg_clear, pktout_reg_clear, resetn_sync;

`ifdef NF_10G_PCSPMA_VECTOR_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif

  nf_10g_if_cpu_regs dut (
    .clk(clk), .resetn(resetn),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .id_reg(id_reg), .version_reg(version_reg), .interfaceid_reg(interfaceid_reg),
    .pktin_reg(pktin_reg), .pktout_reg(pktout_reg), .pcspmastatus_reg(pcspmastatus_reg),
    .ip2cpu_flip_reg(ip2cpu_flip_reg), .ip2cpu_debug_reg(ip2cpu_debug_reg),
    .macstatusvector_reg(macstatusvector_reg),
    .pcspmastatusvector0_reg(pvec[0]),   .pcspmastatusvector1_reg(pvec[1]),
    .pcspmastatusvector2_reg(pvec[2]),   .pcspmastatusvector3_reg(pvec[3]),
    .pcspmastatusvector4_reg(pvec[4]),   .pcspmastatusvector5_reg(pvec[5]),
    .pcspmastatusvector6_reg(pvec[6]),   .pcspmastatusvector7_reg(pvec[7]),
    .pcspmastatusvector8_reg(pvec[8]),   .pcspmastatusvector9_reg(pvec[9]),
    .pcspmastatusvector10_reg(pvec[10]), .pcspmastatusvector11_reg(pvec[11]),
    .pcspmastatusvector12_reg(pvec[12]), .pcspmastatusvector13_reg(pvec[13]),
    .reset_reg(reset_reg), .cpu2ip_flip_reg(cpu2ip_flip_reg), .cpu2ip_debug_reg(cpu2ip_debug_reg),
    .pktin_reg_clear(pktin_reg_clear), .pktout_reg_clear(pktout_reg_clear),
    .resetn_sync(resetn_sync)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_flip, m_debug;

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Memory-map view of the register file built from the current inputs
  function automatic logic [31:0] model_read(input logic [11:0] a);
    logic [31:0] rom [32];
    int w;
    for (int i = 0; i < 32; i++) rom[i] = 32'hDEADBEEF;
    rom[0] = id_reg;           rom[1] = version_reg;
    rom[2] = 32'h0;            rom[3] = ip2cpu_flip_reg;
    rom[4] = ip2cpu_debug_reg; rom[5] = interfaceid_reg;
    rom[6] = pktin_reg;        rom[7] = pktout_reg;
    rom[8] = macstatusvector_reg; rom[9] = pcspmastatus_reg;
    for (int n = 0; n < 14; n++) rom[10+n] = VEC_EN ? pvec[n] : 32'h0;
    w = int'(a >> 2);
    return (w < 32) ? rom[w] : 32'hDEADBEEF;
  endfunction

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int bdly, output logic [31:0] rst_now,
                           output logic [31:0] rst_next);
    bit ok;
    ok = 1'b0;
    rst_next = 32'h0;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (S_AXI_AWREADY) begin ok = 1'b1; break; end
    end
    check("wr_awready_seen", 32'(ok), 32'd1);
    if (ok) check("wr_wready_with_awready", 32'(S_AXI_WREADY), 32'd1);
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    rst_now = reset_reg;
    check("wr_awready_pulse", 32'(S_AXI_AWREADY), 32'd0);
    check("wr_bvalid_rise", 32'(S_AXI_BVALID), 32'd1);
    check("wr_bresp", 32'(S_AXI_BRESP), 32'd0);
    for (int k = 0; k < bdly; k++) begin
      @(posedge clk); #1;
      if (k == 0) rst_next = reset_reg;
      check("wr_bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
    end
    S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    if (bdly == 0) rst_next = reset_reg;
    S_AXI_BREADY = 1'b0;
    check("wr_bvalid_drop", 32'(S_AXI_BVALID), 32'd0);
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d,
                          output int n_in, output int n_out);
    bit ok;
    ok = 1'b0; n_in = 0; n_out = 0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_in += int'(pktin_reg_clear); n_out += int'(pktout_reg_clear);
      if (S_AXI_ARREADY) begin ok = 1'b1; break; end
    end
    check("rd_arready_seen", 32'(ok), 32'd1);
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    n_in += int'(pktin_reg_clear); n_out += int'(pktout_reg_clear);
    check("rd_arready_pulse", 32'(S_AXI_ARREADY), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (S_AXI_RVALID) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("rd_rvalid_seen", 32'(ok), 32'd1);
    check("rd_rresp", 32'(S_AXI_RRESP), 32'd0);
    d = S_AXI_RDATA;
    @(posedge clk); #1;
    n_in += int'(pktin_reg_clear); n_out += int'(pktout_reg_clear);
    check("rd_rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
    check("rd_rdata_stable", S_AXI_RDATA, d);
    S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    S_AXI_RREADY = 1'b0;
    check("rd_rvalid_drop", 32'(S_AXI_RVALID), 32'd0);
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [31:0] exp;
    int          exp_in;
    int          exp_out;
  } rd_vec_t;

  rd_vec_t tv [15];

  initial begin
    logic [31:0] d, r_now, r_next, d2, w2;
    int ni, no;
    logic [11:0] a;
    logic [3:0]  s;
    int op;

    resetn = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    id_reg = 32'h1001DA06; version_reg = 32'h00000001; interfaceid_reg = 32'h00000003;
    pktin_reg = 32'd7; pktout_reg = 32'd9; pcspmastatus_reg = 32'h00000001;
    ip2cpu_flip_reg = 32'hF11F0000; ip2cpu_debug_reg = 32'hDEB00000;
    macstatusvector_reg = 32'h0000ABCD;
    for (int n = 0; n < 14; n++) pvec[n] = 32'hBEE00000 + 32'(n);
    pvec[13] = 32'hCAFE0001;
    m_flip = 32'h0; m_debug = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 32'(S_AXI_AWREADY), 0);
    check("rst_wready", 32'(S_AXI_WREADY), 0);
    check("rst_bvalid", 32'(S_AXI_BVALID), 0);
    check("rst_arready", 32'(S_AXI_ARREADY), 0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 0);
    check("rst_rdata", S_AXI_RDATA, 0);
    check("rst_reset_reg", reset_reg, 0);
    check("rst_flip", cpu2ip_flip_reg, 0);
    check("rst_debug", cpu2ip_debug_reg, 0);
    check("rst_clears", {30'b0, pktin_reg_clear, pktout_reg_clear}, 0);
    check("rst_resetn_sync", 32'(resetn_sync), 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("resetn_sync_release", 32'(resetn_sync), 1);

    // Table-driven reads with fixed input values
    tv[0]  = '{12'h000, 32'h1001DA06, 0, 0};
    tv[1]  = '{12'h004, 32'h00000001, 0, 0};
    tv[2]  = '{12'h008, 32'h00000000, 0, 0};
    tv[3]  = '{12'h00C, 32'hF11F0000, 0, 0};
    tv[4]  = '{12'h010, 32'hDEB00000, 0, 0};
    tv[5]  = '{12'h014, 32'h00000003, 0, 0};
    tv[6]  = '{12'h018, 32'h00000007, 1, 0};
    tv[7]  = '{12'h01C, 32'h00000009, 0, 1};
    tv[8]  = '{12'h020, 32'h0000ABCD, 0, 0};
    tv[9]  = '{12'h024, 32'h00000001, 0, 0};
`ifdef NF_10G_PCSPMA_VECTOR_EN
    tv[10] = '{12'h028, 32'hBEE00000, 0, 0};
    tv[11] = '{12'h05C, 32'hCAFE0001, 0, 0};
`else
    tv[10] = '{12'h028, 32'h00000000, 0, 0};
    tv[11] = '{12'h05C, 32'h00000000, 0, 0};
`endif
    tv[12] = '{12'h060, 32'hDEADBEEF, 0, 0};
    tv[13] = '{12'hFFC, 32'hDEADBEEF, 0, 0};
    tv[14] = '{12'h01A, 32'h00000007, 1, 0};
    for (int i = 0; i < 15; i++) begin
      axi_read(tv[i].addr, d, ni, no);
      check($sformatf("tv_rdata_%03h", tv[i].addr), d, tv[i].exp);
      check($sformatf("tv_pktin_clear_%03h", tv[i].addr), 32'(ni), 32'(tv[i].exp_in));
      check($sformatf("tv_pktout_clear_%03h", tv[i].addr), 32'(no), 32'(tv[i].exp_out));
    end

    // Partial-strobe write with delayed BREADY
    axi_write(12'h00C, 32'hA5A5A5A5, 4'b0011, 3, r_now, r_next);
    m_flip = merge(m_flip, 32'hA5A5A5A5, 4'b0011);
    check("flip_strobe", cpu2ip_flip_reg, 32'h0000A5A5);

    // Self-clearing reset_reg
    axi_write(12'h008, 32'h00000011, 4'hF, 1, r_now, r_next);
    check("reset_reg_pulse", r_now, 32'h11);
    check("reset_reg_cleared", r_next, 32'h0);

    // Unmapped write leaves the RW registers alone
    axi_write(12'h100, 32'h12345678, 4'hF, 0, r_now, r_next);
    check("unmapped_wr_flip", cpu2ip_flip_reg, m_flip);
    check("unmapped_wr_debug", cpu2ip_debug_reg, m_debug);

    // Simultaneous read and write of RESET: read returns the old value
    fork
      axi_write(12'h008, 32'h00000055, 4'hF, 0, r_now, r_next);
      axi_read(12'h008, d2, ni, no);
    join
    check("same_cycle_rd_old", d2, 32'h0);
    check("same_cycle_wr_pulse", r_now, 32'h55);

    // Randomized traffic against the model
    for (int it = 0; it < 200; it++) begin
      id_reg = $urandom; version_reg = $urandom; interfaceid_reg = $urandom;
      pktin_reg = $urandom; pktout_reg = $urandom; pcspmastatus_reg = $urandom;
      ip2cpu_flip_reg = $urandom; ip2cpu_debug_reg = $urandom; macstatusvector_reg = $urandom;
      for (int n = 0; n < 14; n++) pvec[n] = $urandom;
      op = int'($urandom_range(0, 2));
      if (op != 0) begin
        if ($urandom_range(0, 4) == 0) a = 12'($urandom_range(0, 4095));
        else a = 12'($urandom_range(0, 31) * 4);
        axi_read(a, d, ni, no);
        check("rnd_rdata", d, model_read(a));
        check("rnd_pktin_clear", 32'(ni), ((a >> 2) == 12'd6) ? 32'd1 : 32'd0);
        check("rnd_pktout_clear", 32'(no), ((a >> 2) == 12'd7) ? 32'd1 : 32'd0);
      end else begin
        case ($urandom_range(0, 3))
          0: a = 12'h008;
          1: a = 12'h00C;
          2: a = 12'h010;
          default: a = 12'($urandom_range(0, 4095));
        endcase
        w2 = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, w2, s, int'($urandom_range(0, 2)), r_now, r_next);
        if ((a >> 2) == 12'd3) m_flip = merge(m_flip, w2, s);
        if ((a >> 2) == 12'd4) m_debug = merge(m_debug, w2, s);
        check("rnd_flip", cpu2ip_flip_reg, m_flip);
        check("rnd_debug", cpu2ip_debug_reg, m_debug);
        check("rnd_reset_now", r_now, ((a >> 2) == 12'd2) ? merge(32'h0, w2, s) : 32'h0);
        check("rnd_reset_next", r_next, 32'h0);
      end
    end

    // Reset while RVALID is pending aborts the read
    S_AXI_ARADDR = 12'h000; S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (S_AXI_ARREADY) break;
    end
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    check("pre_abort_rvalid", 32'(S_AXI_RVALID), 1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("abort_rvalid", 32'(S_AXI_RVALID), 0);
    check("abort_rdata", S_AXI_RDATA, 0);
    check("abort_flip", cpu2ip_flip_reg, 0);
    check("abort_resetn_sync", 32'(resetn_sync), 0);
    resetn = 1'b1;
    m_flip = 32'h0; m_debug = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("post_abort_rvalid_low", 32'(S_AXI_RVALID), 0);
    id_reg = 32'h1001DA06;
    axi_read(12'h000, d, ni, no);
    check("post_abort_read", d, 32'h1001DA06);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
